// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM single-port bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int unsigned SEL_W = 4;
  localparam logic [SEL_W-1:0] FULL_SEL = 4'b1111;

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'd0,
    ARB_IF_BUSY  = 3'd1,
    ARB_MEM_BUSY = 3'd2,
    ARB_ABORT    = 3'd3,
    ARB_IF_DONE  = 3'd4,
    ARB_MEM_DONE = 3'd5
  } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one Wishbone-style bus between instruction fetch and data access,
// with one outstanding transaction and flush-safe draining of abandoned cycles.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [SEL_W-1:0]  mem_sel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              stallreq_from_if,
  output logic              stallreq_from_mem,
  output logic              bus_cyc_o,
  output logic              bus_stb_o,
  output logic              bus_we_o,
  output logic [SEL_W-1:0]  bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_data_o,
  input  logic [DATA_W-1:0] bus_data_i,
  input  logic              bus_ack_i
);

  arb_state_e        state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

  // Next-state and next-register computation; MEM wins arbitration as the older instruction.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      ARB_IDLE: begin
        if (!flush) begin
          if (mem_req) begin
            cyc_d   = 1'b1;
            we_d    = mem_we;
            sel_d   = mem_sel;
            addr_d  = mem_addr;
            wdata_d = mem_wdata;
            state_d = ARB_MEM_BUSY;
          end else if (if_req) begin
            cyc_d   = 1'b1;
            we_d    = 1'b0;
            sel_d   = FULL_SEL;
            addr_d  = if_addr;
            state_d = ARB_IF_BUSY;
          end
        end
      end

      ARB_IF_BUSY, ARB_MEM_BUSY: begin
        if (bus_ack_i) begin
          cyc_d = 1'b0;
          if (state_q == ARB_IF_BUSY) begin
            if_rdata_d = bus_data_i;
            state_d    = flush ? ARB_IDLE : ARB_IF_DONE;
          end else begin
            if (!we_q) begin
              mem_rdata_d = bus_data_i;
            end
            state_d = flush ? ARB_IDLE : ARB_MEM_DONE;
          end
        end else if (flush) begin
          state_d = ARB_ABORT;
        end
      end

      // Abandoned cycle: hold the strobe until the slave finishes, discard the result.
      ARB_ABORT: begin
        if (bus_ack_i) begin
          cyc_d   = 1'b0;
          state_d = ARB_IDLE;
        end
      end

      ARB_IF_DONE, ARB_MEM_DONE: begin
        state_d = ARB_IDLE;
      end

      default: begin
        cyc_d   = 1'b0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign bus_cyc_o  = cyc_q;
  assign bus_stb_o  = cyc_q;
  assign bus_we_o   = we_q;
  assign bus_sel_o  = sel_q;
  assign bus_addr_o = addr_q;
  assign bus_data_o = wdata_q;
  assign if_rdata   = if_rdata_q;
  assign mem_rdata  = mem_rdata_q;

  // A flush in the completion cycle suppresses the pulse for the squashed instruction.
  assign if_ack  = (state_q == ARB_IF_DONE) & ~flush;
  assign mem_ack = (state_q == ARB_MEM_DONE) & ~flush;

  assign stallreq_from_if  = if_req & ~if_ack & ~flush;
  assign stallreq_from_mem = mem_req & ~mem_ack & ~flush;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed latency/flush/reset cases, then random traffic.
module tb_mem_bus_arbiter;

  typedef struct {
    logic [31:0] data;
    bit          chk;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [3:0]  mem_sel = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] bus_data_i = '0;
  logic        bus_ack_i = 1'b0;

  logic [31:0] if_rdata, mem_rdata, bus_addr_o, bus_data_o;
  logic        if_ack, mem_ack, stallreq_from_if, stallreq_from_mem;
  logic        bus_cyc_o, bus_stb_o, bus_we_o;
  logic [3:0]  bus_sel_o;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stallreq_from_if(stallreq_from_if), .stallreq_from_mem(stallreq_from_mem),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
    .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o),
    .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  exp_t        if_exp_q[$];
  exp_t        mem_exp_q[$];
  logic [31:0] last_load_data = '0;
  bit          last_load_ok = 1'b1;
  logic [31:0] last_if_data = '0;
  int          slave_fixed = 0;
  logic        if_ack_seen = 1'b0;
  logic        mem_ack_seen = 1'b0;

  // Slave memory image: reads are a pure function of address.
  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h3C01_0001;
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic issue_if(input logic [31:0] a);
    if_req  = 1'b1;
    if_addr = a;
    if_exp_q.push_back('{rd_word(a), 1'b1});
  endtask

  // A store must leave mem_rdata at whatever the previous completed load returned.
  task automatic issue_mem(input logic we, input logic [3:0] sel, input logic [31:0] a,
                           input logic [31:0] wd);
    mem_req   = 1'b1;
    mem_we    = we;
    mem_sel   = sel;
    mem_addr  = a;
    mem_wdata = wd;
    if (we) begin
      mem_exp_q.push_back('{last_load_data, last_load_ok});
    end else begin
      mem_exp_q.push_back('{rd_word(a), 1'b1});
      last_load_data = rd_word(a);
      last_load_ok   = 1'b1;
    end
  endtask

  task automatic cancel_pending();
    if_exp_q.delete();
    mem_exp_q.delete();
  endtask

  // Bus slave: acks after a fixed or random number of wait cycles from the first strobe.
  initial begin
    bit in_txn = 1'b0;
    int wcnt = 0;
    int cur_wait = 0;
    forever begin
      @(posedge clk); #1;
      bus_data_i = $urandom;
      if (rst || !bus_stb_o || bus_ack_i) begin
        bus_ack_i = 1'b0;
        in_txn    = 1'b0;
      end else begin
        if (!in_txn) begin
          in_txn   = 1'b1;
          wcnt     = 0;
          cur_wait = (slave_fixed >= 0) ? slave_fixed : $urandom_range(0, 4);
        end
        if (wcnt == cur_wait) begin
          bus_ack_i  = 1'b1;
          bus_data_i = bus_we_o ? $urandom : rd_word(bus_addr_o);
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Monitor: pops expectations on ack pulses and checks each newly started bus cycle.
  initial begin
    logic        prev_stb = 1'b0, prev_rst = 1'b1, prev_flush = 1'b0;
    logic        prev_if_req = 1'b0, prev_mem_req = 1'b0, prev_mem_we = 1'b0;
    logic [3:0]  prev_mem_sel = '0;
    logic [31:0] prev_if_addr = '0, prev_mem_addr = '0, prev_mem_wdata = '0;
    logic [69:0] exp_bus, act_bus;
    exp_t        e;
    forever begin
      @(negedge clk);
      if_ack_seen  = if_ack;
      mem_ack_seen = mem_ack;
      if (if_ack) begin
        check("if_ack_pending", 128'(if_exp_q.size() != 0), 128'(1));
        if (if_exp_q.size() != 0) begin
          e = if_exp_q.pop_front();
          check("if_rdata", 128'(if_rdata), 128'(e.data));
        end
      end
      if (mem_ack) begin
        check("mem_ack_pending", 128'(mem_exp_q.size() != 0), 128'(1));
        if (mem_exp_q.size() != 0) begin
          e = mem_exp_q.pop_front();
          if (e.chk) check("mem_rdata", 128'(mem_rdata), 128'(e.data));
        end
      end
      if (bus_stb_o && !prev_stb) begin
        check("bus_start_requested",
              128'(!prev_rst && !prev_flush && (prev_mem_req || prev_if_req)), 128'(1));
        if (prev_mem_req)
          exp_bus = {1'b1, prev_mem_we, prev_mem_sel, prev_mem_addr,
                     prev_mem_we ? prev_mem_wdata : 32'h0};
        else
          exp_bus = {1'b1, 1'b0, 4'hF, prev_if_addr, 32'h0};
        act_bus = {bus_cyc_o, bus_we_o, bus_sel_o, bus_addr_o, bus_we_o ? bus_data_o : 32'h0};
        check("bus_start_payload", 128'(act_bus), 128'(exp_bus));
      end
      prev_stb       = bus_stb_o;
      prev_rst       = rst;
      prev_flush     = flush;
      prev_if_req    = if_req;
      prev_if_addr   = if_addr;
      prev_mem_req   = mem_req;
      prev_mem_we    = mem_we;
      prev_mem_sel   = mem_sel;
      prev_mem_addr  = mem_addr;
      prev_mem_wdata = mem_wdata;
    end
  end

  // Runs ncyc cycles from the cycle whose inputs the caller just drove, recording timing.
  task automatic run_seq(input int ncyc, input int flush_at, input int rst_at,
                         output logic [31:0] stb_mask, output int stall_if_n,
                         output int stall_mem_n, output int if_ack_at, output int mem_ack_at,
                         output int if_ack_n, output int mem_ack_n);
    stb_mask = '0; stall_if_n = 0; stall_mem_n = 0;
    if_ack_at = -1; mem_ack_at = -1; if_ack_n = 0; mem_ack_n = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        flush = 1'b0;
        if (if_ack_at == i - 1) if_req = 1'b0;
        if (mem_ack_at == i - 1) mem_req = 1'b0;
        if (flush_at >= 0 && i == flush_at + 1) begin if_req = 1'b0; mem_req = 1'b0; end
        if (rst_at >= 0 && i == rst_at + 1) begin if_req = 1'b0; mem_req = 1'b0; end
        if (rst_at >= 0 && i == rst_at + 2) rst = 1'b0;
      end
      if (i == flush_at) begin
        flush = 1'b1;
        cancel_pending();
        last_load_ok = 1'b0;
      end
      if (i == rst_at) begin
        rst = 1'b1;
        cancel_pending();
        last_load_data = '0;
        last_load_ok   = 1'b1;
        last_if_data   = '0;
      end
      @(negedge clk);
      stb_mask[i] = bus_stb_o;
      if (stallreq_from_if) stall_if_n++;
      if (stallreq_from_mem) stall_mem_n++;
      if (if_ack) begin if_ack_n++; if_ack_at = i; end
      if (mem_ack) begin mem_ack_n++; mem_ack_at = i; end
    end
  endtask

  initial begin
    logic [31:0] m;
    int sif, smem, ifat, memat, ifn, memn, if_age, mem_age;

    // Reset held with a fetch pending
    if_req = 1'b1; if_addr = 32'h0000_0040;
    repeat (3) begin
      @(negedge clk);
      check("reset_cyc_stb", 128'({bus_cyc_o, bus_stb_o}), 128'(0));
    end
    check("reset_bus_regs", 128'({bus_we_o, bus_sel_o, bus_addr_o, bus_data_o}), 128'(0));
    check("reset_rdata", 128'({if_rdata, mem_rdata}), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    if_exp_q.push_back('{rd_word(32'h40), 1'b1});
    last_if_data = rd_word(32'h40);
    run_seq(6, -1, -1, m, sif, smem, ifat, memat, ifn, memn);
    check("rst_release_stb_mask", 128'(m), 128'(32'h2));
    check("rst_release_ack_cycle", 128'(ifat), 128'(2));

    // Zero-wait fetch
    @(posedge clk); #1;
    issue_if(32'h0000_0100);
    last_if_data = 32'h3C01_0001;
    run_seq(5, -1, -1, m, sif, smem, ifat, memat, ifn, memn);
    check("fetch_ack_cycle", 128'(ifat), 128'(2));
    check("fetch_ack_count", 128'(ifn), 128'(1));
    check("fetch_stall_cycles", 128'(sif), 128'(2));

    // Simultaneous store and fetch: store first, one idle cycle, then fetch
    @(posedge clk); #1;
    issue_mem(1'b1, 4'b0011, 32'h0000_0200, 32'h0000_BEEF);
    issue_if(32'h0000_0104);
    last_if_data = rd_word(32'h104);
    run_seq(8, -1, -1, m, sif, smem, ifat, memat, ifn, memn);
    check("both_mem_ack_cycle", 128'(memat), 128'(2));
    check("both_if_ack_cycle", 128'(ifat), 128'(5));
    check("both_stb_mask", 128'(m), 128'(32'h12));
    check("both_if_stall_cycles", 128'(sif), 128'(5));
    check("both_mem_stall_cycles", 128'(smem), 128'(2));

    // Load with three slave wait cycles
    slave_fixed = 3;
    @(posedge clk); #1;
    issue_mem(1'b0, 4'b1111, 32'h0000_0300, 32'h0);
    run_seq(8, -1, -1, m, sif, smem, ifat, memat, ifn, memn);
    check("wait_mem_ack_cycle", 128'(memat), 128'(5));
    check("wait_mem_stall_cycles", 128'(smem), 128'(5));
    check("wait_stb_mask", 128'(m), 128'(32'h1E));

    // Flush mid-fetch: cycle drains through abort, no ack, rdata kept
    @(posedge clk); #1;
    issue_if(32'h0000_0108);
    run_seq(8, 2, -1, m, sif, smem, ifat, memat, ifn, memn);
    check("abort_stb_mask", 128'(m), 128'(32'h1E));
    check("abort_no_ack", 128'(ifn), 128'(0));
    check("abort_if_rdata_kept", 128'(if_rdata), 128'(last_if_data));

    // Flush coincident with the fetch completion cycle
    slave_fixed = 0;
    @(posedge clk); #1;
    issue_if(32'h0000_010C);
    run_seq(5, 2, -1, m, sif, smem, ifat, memat, ifn, memn);
    check("done_flush_no_ack", 128'(ifn), 128'(0));
    check("done_flush_stb_mask", 128'(m), 128'(32'h2));

    // Reset during a pending load
    slave_fixed = 5;
    @(posedge clk); #1;
    issue_mem(1'b0, 4'b1111, 32'h0000_0400, 32'h0);
    run_seq(8, 2, -1 + 3, m, sif, smem, ifat, memat, ifn, memn);
    check("rst_mid_stb_mask", 128'(m), 128'(32'h6));
    check("rst_mid_no_ack", 128'(memn), 128'(0));
    check("rst_mid_rdata", 128'({if_rdata, mem_rdata}), 128'(0));

    // Random traffic with random slave latency and occasional flushes
    slave_fixed = -1;
    if_age = 0; mem_age = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk); #1;
      if (if_req && if_ack_seen) if_req = 1'b0;
      if (mem_req && mem_ack_seen) mem_req = 1'b0;
      if (flush) begin
        flush = 1'b0; if_req = 1'b0; mem_req = 1'b0;
      end else if ($urandom_range(0, 24) == 0) begin
        flush = 1'b1;
        cancel_pending();
        last_load_ok = 1'b0;
      end else begin
        if (!if_req && $urandom_range(0, 2) == 0) issue_if($urandom & 32'hFFFF_FFFC);
        if (!mem_req && $urandom_range(0, 2) == 0)
          issue_mem(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
                    $urandom & 32'hFFFF_FFFC, $urandom);
      end
      if (if_req) if_age++; else if_age = 0;
      if (mem_req) mem_age++; else mem_age = 0;
      if (if_age > 200) begin
        check("if_ack_within_bound", 128'(if_age <= 200), 128'(1));
        if_req = 1'b0; if_exp_q.delete(); if_age = 0;
      end
      if (mem_age > 200) begin
        check("mem_ack_within_bound", 128'(mem_age <= 200), 128'(1));
        mem_req = 1'b0; mem_exp_q.delete(); mem_age = 0;
      end
    end

    // Drain outstanding requests with a bounded wait
    for (int cyc = 0; cyc < 100 && (if_req || mem_req || flush); cyc++) begin
      @(posedge clk); #1;
      if (flush) begin flush = 1'b0; if_req = 1'b0; mem_req = 1'b0; cancel_pending(); end
      if (if_req && if_ack_seen) if_req = 1'b0;
      if (mem_req && mem_ack_seen) mem_req = 1'b0;
    end
    repeat (10) @(negedge clk);
    check("drain_reqs_done", 128'({if_req, mem_req}), 128'(0));
    check("drain_if_queue_empty", 128'(if_exp_q.size()), 128'(0));
    check("drain_mem_queue_empty", 128'(mem_exp_q.size()), 128'(0));
    check("drain_bus_idle", 128'({bus_cyc_o, bus_stb_o}), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
